// File: rtl/l1d_evict_wbuf.sv
// rtl/l1d_evict_wbuf.sv - in-order L1D eviction write buffer with linefill hazard probe (optional bypass: L1D_EVICT_WBUF_BYPASS_EN)
module l1d_evict_wbuf #(
  parameter int ADDR_WIDTH = 40,
  parameter int LINE_WIDTH = 512,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  evict_vld,
  output logic                  evict_rdy,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  input  logic [LINE_WIDTH-1:0] evict_dat,
  output logic                  mem_wr_vld,
  input  logic                  mem_wr_rdy,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [LINE_WIDTH-1:0] mem_wr_dat,
  input  logic                  mem_wr_ack,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic                  chk_hit,
  output logic                  wbuf_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    E_FREE   = 2'd0,
    E_PEND   = 2'd1,
    E_ISSUED = 2'd2
  } ent_state_e;

  ent_state_e            ent_state [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_addr  [DEPTH];
  logic [LINE_WIDTH-1:0] ent_dat   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] iss_ptr;
  logic [PW-1:0] ack_ptr;
  logic [CW-1:0] count;

  logic alloc;
  logic issue;
  logic ack_ok;
  logic bypass;

  // Ready comes only from the registered count, so an ack this cycle frees space next cycle.
  assign evict_rdy  = (count < FULL_CNT);
  assign wbuf_empty = (count == '0);
  assign alloc      = evict_vld & evict_rdy;
  // Acks are in order; one arriving when the oldest outstanding slot is not ISSUED is stray.
  assign ack_ok     = mem_wr_ack & (ent_state[ack_ptr] == E_ISSUED);
  assign issue      = mem_wr_vld & mem_wr_rdy;

  // Memory request mux: oldest PEND entry, or the incoming evict when bypassing an empty buffer.
  always_comb begin
    mem_wr_vld  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_dat  = '0;
    bypass      = 1'b0;
    if (ent_state[iss_ptr] == E_PEND) begin
      mem_wr_vld  = 1'b1;
      mem_wr_addr = ent_addr[iss_ptr];
      mem_wr_dat  = ent_dat[iss_ptr];
    end
`ifdef L1D_EVICT_WBUF_BYPASS_EN
    else if (wbuf_empty && evict_vld) begin
      bypass      = 1'b1;
      mem_wr_vld  = 1'b1;
      mem_wr_addr = evict_addr;
      mem_wr_dat  = evict_dat;
    end
`endif
  end

  // Entry state, pointers and occupancy; alloc/issue/ack touch distinct slots except in bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i] <= E_FREE;
      end
      wr_ptr  <= '0;
      iss_ptr <= '0;
      ack_ptr <= '0;
      count   <= '0;
    end else begin
      if (ack_ok) begin
        ent_state[ack_ptr] <= E_FREE;
        ack_ptr            <= ack_ptr + PTR_ONE;
      end
      if (issue) begin
        if (!bypass) begin
          ent_state[iss_ptr] <= E_ISSUED;
        end
        iss_ptr <= iss_ptr + PTR_ONE;
      end
      if (alloc) begin
        // A bypassed evict taken by memory in the same cycle goes straight to ISSUED.
        ent_state[wr_ptr] <= (bypass && mem_wr_rdy) ? E_ISSUED : E_PEND;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      count <= count + CW'(alloc) - CW'(ack_ok);
    end
  end

  // Line payload storage; validity is tracked by ent_state so no reset is needed here.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[wr_ptr] <= evict_addr;
      ent_dat[wr_ptr]  <= evict_dat;
    end
  end

  // Hazard probe over stored entries only; the evict being accepted now is not yet visible.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ent_state[i] != E_FREE) && (ent_addr[i] == chk_addr)) begin
        chk_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1d_evict_wbuf.sv
// tb/tb_l1d_evict_wbuf.sv - self-checking bench for l1d_evict_wbuf against a queue-based model
module tb_l1d_evict_wbuf;

  localparam int AW    = 40;
  localparam int LW    = 512;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          evict_vld = 1'b0;
  logic          evict_rdy;
  logic [AW-1:0] evict_addr = '0;
  logic [LW-1:0] evict_dat = '0;
  logic          mem_wr_vld;
  logic          mem_wr_rdy = 1'b0;
  logic [AW-1:0] mem_wr_addr;
  logic [LW-1:0] mem_wr_dat;
  logic          mem_wr_ack = 1'b0;
  logic [AW-1:0] chk_addr = '0;
  logic          chk_hit;
  logic          wbuf_empty;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } ent_t;

  ent_t pend[$];
  ent_t iss[$];

  l1d_evict_wbuf #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_vld(evict_vld), .evict_rdy(evict_rdy), .evict_addr(evict_addr), .evict_dat(evict_dat),
    .mem_wr_vld(mem_wr_vld), .mem_wr_rdy(mem_wr_rdy), .mem_wr_addr(mem_wr_addr), .mem_wr_dat(mem_wr_dat),
    .mem_wr_ack(mem_wr_ack), .chk_addr(chk_addr), .chk_hit(chk_hit), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int occ();
    return pend.size() + iss.size();
  endfunction

  function automatic logic model_hit(input logic [AW-1:0] a);
    foreach (pend[i]) if (pend[i].a == a) return 1'b1;
    foreach (iss[i]) if (iss[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic r, input logic k,
                       input logic [AW-1:0] c);
    @(negedge clk);
    evict_vld  = v;
    evict_addr = a;
    evict_dat  = rand_line();
    mem_wr_rdy = r;
    mem_wr_ack = k;
    chk_addr   = c;
    #1;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic commit();
    logic do_alloc, do_issue, do_ack;
    ent_t e;
    do_alloc = evict_vld && (occ() < DEPTH);
    do_issue = (pend.size() > 0) && mem_wr_rdy;
    do_ack   = mem_wr_ack && (iss.size() > 0);
    @(posedge clk);
    if (do_ack) void'(iss.pop_front());
    if (do_issue) begin
      e = pend.pop_front();
      iss.push_back(e);
    end
    if (do_alloc) pend.push_back({evict_addr, evict_dat});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    evict_vld = 1'b0; mem_wr_rdy = 1'b0; mem_wr_ack = 1'b0;
    pend.delete();
    iss.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; evict_vld = 1'b1; evict_addr = 40'h140; mem_wr_rdy = 1'b1; chk_addr = 40'h140;
    @(posedge clk);
    #1;
    vectors++;
    if ({evict_rdy, mem_wr_vld, chk_hit, wbuf_empty} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/vld/hit/empty=%b want 1001", {evict_rdy, mem_wr_vld, chk_hit, wbuf_empty});
    end
    vectors++;
    if (mem_wr_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 0", mem_wr_addr);
    end
    vectors++;
    if (mem_wr_dat !== '0) begin
      miscompares++;
      $display("FAIL reset_dat: got %h want 0", mem_wr_dat);
    end
    evict_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 40'h100, 1'b1, 1'b0, 40'h100);
    vectors++;
    if ({evict_rdy, mem_wr_vld, chk_hit} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_accept: got rdy/vld/hit=%b want 100", {evict_rdy, mem_wr_vld, chk_hit});
    end
    commit();
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h100);
    vectors++;
    if ({mem_wr_vld, mem_wr_addr, chk_hit} !== {1'b1, 40'h100, 1'b1}) begin
      miscompares++;
      $display("FAIL single_issue: got vld=%b addr=%h hit=%b want 1 100 1", mem_wr_vld, mem_wr_addr, chk_hit);
    end
    commit();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h100);
      vectors++;
      if ({mem_wr_vld, wbuf_empty} !== 2'b00) begin
        miscompares++;
        $display("FAIL single_wait: got vld/empty=%b want 00", {mem_wr_vld, wbuf_empty});
      end
      commit();
    end
    drive(1'b0, 40'h0, 1'b1, 1'b1, 40'h100);
    commit();
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h100);
    vectors++;
    if ({wbuf_empty, chk_hit, evict_rdy} !== 3'b101) begin
      miscompares++;
      $display("FAIL single_done: got empty/hit/rdy=%b want 101", {wbuf_empty, chk_hit, evict_rdy});
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, AW'(40'h1000 + i * 64), 1'b0, 1'b0, 40'h0);
      vectors++;
      if (evict_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_rdy%0d: got %b want 1", i, evict_rdy);
      end
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 40'h2000, 1'b0, 1'b0, 40'h2000);
      vectors++;
      if ({evict_rdy, mem_wr_vld, mem_wr_addr, chk_hit} !== {1'b0, 1'b1, 40'h1000, 1'b0}) begin
        miscompares++;
        $display("FAIL full_holdoff: got rdy=%b vld=%b addr=%h hit=%b want 0 1 1000 0",
                 evict_rdy, mem_wr_vld, mem_wr_addr, chk_hit);
      end
      commit();
    end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(1'b1, 40'h2C0, 1'b1, 1'b0, 40'h2C0);
    commit();
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h2C0);
    commit();
    drive(1'b0, 40'h0, 1'b0, 1'b0, 40'h2C0);
    vectors++;
    if ({chk_hit, mem_wr_vld} !== 2'b10) begin
      miscompares++;
      $display("FAIL hazard_issued: got hit/vld=%b want 10", {chk_hit, mem_wr_vld});
    end
    drive(1'b0, 40'h0, 1'b0, 1'b1, 40'h2C0);
    vectors++;
    if (chk_hit !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_ack_cycle: got %b want 1", chk_hit);
    end
    commit();
    drive(1'b0, 40'h0, 1'b0, 1'b0, 40'h2C0);
    vectors++;
    if (chk_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_cleared: got %b want 0", chk_hit);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, AW'(40'h3000 + i * 64), 1'b0, 1'b0, 40'h0);
      commit();
    end
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h0);
    commit();
    drive(1'b1, 40'h4000, 1'b1, 1'b1, 40'h4000);
    vectors++;
    if ({evict_rdy, mem_wr_vld, mem_wr_addr, chk_hit} !== {1'b0, 1'b1, 40'h3040, 1'b0}) begin
      miscompares++;
      $display("FAIL simul_refused: got rdy=%b vld=%b addr=%h hit=%b want 0 1 3040 0",
               evict_rdy, mem_wr_vld, mem_wr_addr, chk_hit);
    end
    commit();
    drive(1'b1, 40'h4000, 1'b0, 1'b0, 40'h4000);
    vectors++;
    if ({evict_rdy, chk_hit} !== 2'b10) begin
      miscompares++;
      $display("FAIL simul_accept: got rdy/hit=%b want 10", {evict_rdy, chk_hit});
    end
    commit();
    drive(1'b0, 40'h0, 1'b0, 1'b0, 40'h4000);
    vectors++;
    if ({evict_rdy, chk_hit, wbuf_empty, 32'(occ())} !== {3'b010, 32'd4}) begin
      miscompares++;
      $display("FAIL simul_count4: got rdy/hit/empty=%b model_occ=%0d want 010 4",
               {evict_rdy, chk_hit, wbuf_empty}, occ());
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(40'h5000 + i * 64), 1'b0, 1'b0, 40'h0);
      commit();
    end
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h5040);
    commit();
    @(negedge clk);
    rst_n = 1'b0;
    mem_wr_rdy = 1'b0;
    pend.delete();
    iss.delete();
    #1;
    vectors++;
    if ({evict_rdy, mem_wr_vld, chk_hit, wbuf_empty, mem_wr_addr} !== {4'b1001, 40'h0} || mem_wr_dat !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got rdy/vld/hit/empty=%b addr=%h want 1001 0",
               {evict_rdy, mem_wr_vld, chk_hit, wbuf_empty}, mem_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 40'h0, 1'b1, 1'b1, 40'h5040);
    commit();
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h5040);
    vectors++;
    if ({evict_rdy, mem_wr_vld, chk_hit, wbuf_empty} !== 4'b1001) begin
      miscompares++;
      $display("FAIL stray_ack: got rdy/vld/hit/empty=%b want 1001", {evict_rdy, mem_wr_vld, chk_hit, wbuf_empty});
    end
    drive(1'b1, 40'h6000, 1'b1, 1'b0, 40'h6000);
    commit();
    drive(1'b0, 40'h0, 1'b1, 1'b0, 40'h6000);
    vectors++;
    if ({mem_wr_vld, mem_wr_addr, chk_hit} !== {1'b1, 40'h6000, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_issue: got vld=%b addr=%h hit=%b want 1 6000 1", mem_wr_vld, mem_wr_addr, chk_hit);
    end
    commit();
  endtask

  task automatic test_random_order();
    logic [3:0] exp_flags;
    logic       v, r, k;
    logic [AW-1:0] a, c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 1);
      k = (iss.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      a = AW'($urandom_range(0, 15)) << 6;
      c = AW'($urandom_range(0, 15)) << 6;
      drive(v, a, r, k, c);
      exp_flags = {occ() < DEPTH, pend.size() > 0, model_hit(c), occ() == 0};
      vectors++;
      if ({evict_rdy, mem_wr_vld, chk_hit, wbuf_empty} !== exp_flags) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: got rdy/vld/hit/empty=%b want %b", n,
                 {evict_rdy, mem_wr_vld, chk_hit, wbuf_empty}, exp_flags);
      end
      if (pend.size() > 0) begin
        vectors++;
        if (mem_wr_addr !== pend[0].a || mem_wr_dat !== pend[0].d) begin
          miscompares++;
          $display("FAIL rand_payload[%0d]: got addr %h want %h", n, mem_wr_addr, pend[0].a);
        end
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_full();
    test_hazard();
    test_simultaneous();
    test_mid_reset();
    test_random_order();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
